abr_sha3_squeeze_ctrl: RTL

Hardware squeeze sequencer for the SHA3/SHAKE/cSHAKE core. It sits between the SHA3 core's digest/state port and downstream consumers such as the ML-DSA/ML-KEM samplers. It streams an arbitrary-length XOF output as OutW-bit words over a valid/ready interface. When the rate portion of the state is exhausted it issues keccak run pulses itself, so software no longer has to drive manual `run_i` sequences. It generalises the single-block digest readout to configurable word width, configurable output length and share count.

---
 rtl/abr_sha3_pkg.sv | 58 +++++
 rtl/abr_sha3_squeeze_cnt.sv | 48 ++++
 rtl/abr_sha3_squeeze_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/abr_sha3_pkg.sv
// Shared SHA3 types: keccak strengths, mubi4 encoding,
// squeeze FSM sparse codes and rate helpers.
package abr_sha3_pkg;

  localparam int StateW = 1600;
  localparam int IdxW   = 6;

  typedef enum logic [2:0] {
    L128 = 3'd0,
    L224 = 3'd1,
    L256 = 3'd2,
    L384 = 3'd3,
    L512 = 3'd4
  } keccak_strength_e;

  typedef logic [3:0] mubi4_t;
  localparam mubi4_t MuBi4True  = 4'h6;
  localparam mubi4_t MuBi4False = 4'h9;

  localparam int RateL128 = 1344;
  localparam int RateL224 = 1152;
  localparam int RateL256 = 1088;
  localparam int RateL384 = 832;
  localparam int RateL512 = 576;

  // Codewords of a (6,3) code: pairwise distance >= 3
  typedef enum logic [5:0] {
    SqIdle       = 6'b100110,
    SqWaitAbsorb = 6'b010101,
    SqWaitValid  = 6'b001011,
    SqStream     = 6'b110011,
    SqWaitRun    = 6'b101101,
    SqTerminal   = 6'b011110
  } squeeze_st_sparse_e;

  function automatic logic mubi4_test_true_strict(
    input mubi4_t v
  );
    return v == MuBi4True;
  endfunction

  function automatic logic [IdxW-1:0] rate_words(
    input keccak_strength_e s,
    input int ow
  );
    int bits;
    case (s)
      L128:    bits = RateL128;
      L224:    bits = RateL224;
      L256:    bits = RateL256;
      L384:    bits = RateL384;
      L512:    bits = RateL512;
      default: bits = 0;
    endcase
    return IdxW'(bits / ow);
  endfunction

endpackage

// File: rtl/abr_sha3_squeeze_cnt.sv
// Squeeze word counters: word index within the rate block,
// remaining words, boundary/last compares and range check.
module abr_sha3_squeeze_cnt
  import abr_sha3_pkg::*;
#(
  parameter int LenW = 16
) (
  input  logic            clk_i,
  input  logic            rst_b,
  input  logic            zeroize,
  input  logic            load,
  input  logic [LenW-1:0] len,
  input  logic [IdxW-1:0] rate_in,
  input  logic            adv,
  output logic [IdxW-1:0] word_idx,
  output logic            last,
  output logic            boundary,
  output logic            count_error
);

  logic [LenW-1:0] remaining;
  logic [IdxW-1:0] rate;

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      remaining <= '0;
      word_idx  <= '0;
      rate      <= '0;
    end else if (zeroize) begin
      remaining <= '0;
      word_idx  <= '0;
      rate      <= '0;
    end else if (load) begin
      remaining <= len;
      word_idx  <= '0;
      rate      <= rate_in;
    end else if (adv) begin
      remaining <= remaining - LenW'(1);
      word_idx  <= boundary ? '0 : word_idx + IdxW'(1);
    end
  end

  assign last     = remaining == LenW'(1);
  assign boundary = word_idx == rate - IdxW'(1);
  // rate is zero only before the first job
  assign count_error = (rate != '0) && (word_idx >= rate);

endmodule

// File: rtl/abr_sha3_squeeze_ctrl.sv
// SHA3 XOF squeeze sequencer: streams OutW-bit words and
// issues keccak run pulses at rate-block boundaries.
module abr_sha3_squeeze_ctrl
  import abr_sha3_pkg::*;
#(
  parameter  int OutW      = 64,
  parameter  int LenW      = 16,
  parameter  int EnMasking = 0,
  localparam int Share     = EnMasking ? 2 : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_b,
  input  logic                         zeroize,
  input  logic                         start_i,
  input  logic [LenW-1:0]              out_len_i,
  input  keccak_strength_e             strength_i,
  input  mubi4_t                       absorbed_i,
  input  logic                         state_valid_i,
  input  logic [Share-1:0][StateW-1:0] state_i,
  input  logic                         block_processed_i,
  output logic                         run_o,
  output logic                         state_valid_hold_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [Share-1:0][OutW-1:0]   out_data_o,
  output logic                         out_last_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic                         sparse_fsm_error_o,
  output logic                         count_error_o
);

  squeeze_st_sparse_e state_q, state_d;
  logic [IdxW-1:0] word_idx, rate_sel;
  logic last, boundary, count_err;
  logic load, hs, stream;
  logic run_d, done_d, err_d, fsm_err;
  logic run_q, done_q, err_q;

  assign rate_sel = rate_words(strength_i, OutW);
  assign stream   = state_q == SqStream;
  assign hs       = out_valid_o & out_ready_i;

  abr_sha3_squeeze_cnt #(
    .LenW (LenW)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_b       (rst_b),
    .zeroize     (zeroize),
    .load        (load),
    .len         (out_len_i),
    .rate_in     (rate_sel),
    .adv         (hs),
    .word_idx    (word_idx),
    .last        (last),
    .boundary    (boundary),
    .count_error (count_err)
  );

  always_comb begin
    state_d = state_q;
    run_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    fsm_err = 1'b0;
    case (state_q)
      SqIdle: begin
        if (start_i) begin
          if (rate_sel == '0) begin
            err_d = 1'b1;
          end else begin
            load = 1'b1;
            if (out_len_i == '0) done_d  = 1'b1;
            else                 state_d = SqWaitAbsorb;
          end
        end
      end
      SqWaitAbsorb: begin
        if (mubi4_test_true_strict(absorbed_i))
          state_d = SqWaitValid;
      end
      SqWaitValid: begin
        if (state_valid_i) state_d = SqStream;
      end
      SqStream: begin
        // last word wins over a coincident block boundary
        if (hs && last) begin
          done_d  = 1'b1;
          state_d = SqIdle;
        end else if (hs && boundary) begin
          run_d   = 1'b1;
          state_d = SqWaitRun;
        end
      end
      SqWaitRun: begin
        if (block_processed_i) state_d = SqWaitValid;
      end
      SqTerminal: begin
        fsm_err = 1'b1;
      end
      default: begin
        fsm_err = 1'b1;
        state_d = SqTerminal;
      end
    endcase
    if (start_i && state_q != SqIdle) err_d = 1'b1;
    if (count_err) state_d = SqTerminal;
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= SqIdle;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (zeroize) begin
      state_q <= SqIdle;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  for (genvar s = 0; s < Share; s++) begin : g_share
    logic [StateW-1:0] sh;
    assign sh = state_i[s] >> (32'(word_idx) * 32'(OutW));
    assign out_data_o[s] = stream ? sh[OutW-1:0] : '0;
  end

  assign out_valid_o        = stream & state_valid_i;
  assign out_last_o         = stream & last;
  assign state_valid_hold_o = stream;
  assign busy_o             = state_q != SqIdle;
  assign run_o              = run_q;
  assign done_o             = done_q;
  assign error_o            = err_q;
  assign sparse_fsm_error_o = fsm_err;
  assign count_error_o      = count_err;

endmodule
